// File: rtl/divide_sequencer_pkg.sv
// Shared types and constants for the register-file divide sequencer.
package divide_sequencer_pkg;
  localparam int BITS_DEFAULT = 32;
  localparam int ADDR_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DIV,
    WR_Q,
    WR_R,
    DONE
  } state_t;
endpackage

// File: rtl/divide_core.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
module divide_core #(
  parameter int BITS  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            last
);
  localparam int RW = BITS + 1;

  logic [BITS:0]   rem;
  logic [BITS-1:0] quo;
  logic [BITS-1:0] dsr;
  logic [CNT_W-1:0] cnt;
  logic [BITS+1:0] trial;
  logic            ge;

  // quo doubles as the dividend shift register; its MSB feeds the trial value
  assign trial = {rem, quo[BITS-1]};
  assign ge    = trial >= {2'b00, dsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      dsr <= divisor;
      cnt <= CNT_W'(BITS);
      if (divisor == '0) begin
        quo <= '1;
        rem <= {1'b0, dividend};
      end else begin
        quo <= dividend;
        rem <= '0;
      end
    end else if (step) begin
      rem <= ge ? RW'(trial - {2'b00, dsr}) : RW'(trial);
      quo <= {quo[BITS-2:0], ge};
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign quotient  = quo;
  assign remainder = rem[BITS-1:0];
  assign last      = cnt == CNT_W'(1);
endmodule

// File: rtl/divide_sequencer.sv
// Reads two registers, divides them, writes quotient then remainder back.
module divide_sequencer
  import divide_sequencer_pkg::*;
#(
  parameter int BITS  = BITS_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] SrcA,
  input  logic [ADDR_W-1:0] SrcB,
  input  logic [ADDR_W-1:0] DestQ,
  input  logic [ADDR_W-1:0] DestR,
  output logic [ADDR_W-1:0] AddrA,
  output logic [ADDR_W-1:0] AddrB,
  input  logic [BITS-1:0]   DataA,
  input  logic [BITS-1:0]   DataB,
  output logic              Write,
  output logic [ADDR_W-1:0] DestAddr,
  output logic [BITS-1:0]   DestData,
  output logic              busy,
  output logic              done,
  output logic              divz
);
  state_t state, next;
  logic [ADDR_W-1:0] src_a, src_b, dest_q, dest_r;
  logic divz_q, load, step, last;
  logic [BITS-1:0] quotient, remainder;

  divide_core #(.BITS(BITS), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend (DataA),
    .divisor  (DataB),
    .quotient (quotient),
    .remainder(remainder),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      src_a  <= '0;
      src_b  <= '0;
      dest_q <= '0;
      dest_r <= '0;
      divz_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        src_a  <= SrcA;
        src_b  <= SrcB;
        dest_q <= DestQ;
        dest_r <= DestR;
      end
      if (state == READ) divz_q <= DataB == '0;
    end
  end

  always_comb begin
    next     = state;
    load     = 1'b0;
    step     = 1'b0;
    Write    = 1'b0;
    DestAddr = '0;
    DestData = '0;
    case (state)
      IDLE: if (start) next = READ;
      READ: begin
        load = 1'b1;
        next = (DataB == '0) ? WR_Q : DIV;
      end
      DIV: begin
        step = 1'b1;
        if (last) next = WR_Q;
      end
      WR_Q: begin
        Write    = 1'b1;
        DestAddr = dest_q;
        DestData = quotient;
        next     = WR_R;
      end
      WR_R: begin
        Write    = 1'b1;
        DestAddr = dest_r;
        DestData = remainder;
        next     = DONE;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Operands are sampled in READ, so read ports can follow the latched sources
  assign AddrA = src_a;
  assign AddrB = src_b;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign divz  = done & divz_q;
endmodule
